// File: rtl/rfid_pkg.sv
// rfid_pkg: shared state/sequence types and constants for the ISO 14443A PCD->PICC receive path
package rfid_pkg;
    typedef enum logic [1:0] {IDLE, RECEIVE, FLUSH, REPORT} state_t;
    typedef enum logic [1:0] {SEQ_X, SEQ_Y, SEQ_Z} seq_t;
    localparam int TICKS_PER_BIT_106K = 32;
    localparam bit PARITY_ODD = 1'b1;
endpackage

// File: rtl/miller_frame_decoder_pause_edge_sync.sv
// pause_edge_sync: 2-FF synchronizer on the pause envelope plus rising-edge detect
module pause_edge_sync (
    input  logic clk_in,
    input  logic rst_in,
    input  logic pause_in,
    output logic pause_edge
);
    logic [2:0] sync;
    // two metastability stages, third stage remembers the previous synchronized level
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) sync <= '0;
        else sync <= {sync[1:0], pause_in};
    assign pause_edge = sync[1] & ~sync[2];
endmodule

// File: rtl/miller_frame_decoder.sv
// miller_frame_decoder: modified Miller (106 kbit/s) PICC receiver producing bytes, parity status and frame reports
module miller_frame_decoder
    import rfid_pkg::*;
#(
    parameter int TICKS_PER_BIT = TICKS_PER_BIT_106K,
    parameter int MAX_BYTES     = 32
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             pause_in,
    input  logic                             rx_en_in,
    output logic [7:0]                       data_out,
    output logic [3:0]                       valid_bits_out,
    output logic                             parity_err_out,
    output logic                             data_valid_out,
    output logic                             frame_done_out,
    output logic                             frame_err_out,
    output logic [$clog2(MAX_BYTES+1)-1:0]   byte_count_out,
    output logic                             busy_out
);
    localparam int PW = $clog2(TICKS_PER_BIT);
    localparam int BW = $clog2(MAX_BYTES + 1);
    localparam logic [PW-1:0] PH_1Q  = PW'(TICKS_PER_BIT / 4);
    localparam logic [PW-1:0] PH_HALF = PW'(TICKS_PER_BIT / 2);
    localparam logic [PW-1:0] PH_3Q  = PW'(3 * TICKS_PER_BIT / 4);
    localparam logic [PW-1:0] PH_END = PW'(TICKS_PER_BIT - 1);

    state_t        state;
    logic [PW-1:0] phase;
    logic [1:0]    win_n;
    logic          win_x, first, prev_bit;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [BW-1:0] byte_cnt;
    logic          edge_det;

    logic [1:0] n_now;
    logic       x_edge, x_now, win_end, viol, eof, bit_val, abort;
    seq_t       seq;

    pause_edge_sync u_sync (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .pause_in   (pause_in),
        .pause_edge (edge_det)
    );

    assign busy_out       = state != IDLE;
    assign byte_count_out = byte_cnt;

    // classify the current window including an edge landing on this very cycle
    always_comb begin
        x_edge  = phase >= PH_HALF;
        n_now   = win_n + {1'b0, edge_det & ~win_n[1]};
        x_now   = win_x | (edge_det & x_edge);
        win_end = phase == PH_END;
        seq     = n_now == 2'd0 ? SEQ_Y : (x_now ? SEQ_X : SEQ_Z);
        viol    = n_now[1] | (seq == SEQ_Z & prev_bit);
        eof     = seq == SEQ_Y & ~prev_bit;
        bit_val = seq == SEQ_X;
        abort   = state == RECEIVE & (~rx_en_in | (win_end & (n_now[1] |
                  (~first & (viol | (~eof & byte_cnt == BW'(MAX_BYTES)))))));
    end

    // frame FSM: phase grid, bit assembly and all registered outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            phase          <= '0;
            win_n          <= '0;
            win_x          <= 1'b0;
            first          <= 1'b0;
            prev_bit       <= 1'b0;
            bit_cnt        <= '0;
            shreg          <= '0;
            byte_cnt       <= '0;
            data_out       <= '0;
            valid_bits_out <= '0;
            parity_err_out <= 1'b0;
            data_valid_out <= 1'b0;
            frame_done_out <= 1'b0;
            frame_err_out  <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            frame_done_out <= 1'b0;
            case (state)
                IDLE: if (rx_en_in && edge_det) begin
                    state    <= RECEIVE;
                    phase    <= PH_1Q;
                    win_n    <= 2'd1;
                    win_x    <= 1'b0;
                    first    <= 1'b1;
                    prev_bit <= 1'b0;
                    bit_cnt  <= '0;
                    shreg    <= '0;
                    byte_cnt <= '0;
                end
                RECEIVE: begin
                    phase <= edge_det ? (x_edge ? PH_3Q : PH_1Q) : (win_end ? '0 : phase + 1'b1);
                    win_n <= win_end ? 2'd0 : n_now;
                    win_x <= win_end ? 1'b0 : x_now;
                    if (abort) begin
                        state          <= REPORT;
                        frame_done_out <= 1'b1;
                        frame_err_out  <= 1'b1;
                    end else if (win_end && first) begin
                        first <= 1'b0;
                    end else if (win_end && eof) begin
                        if (bit_cnt > 4'd1) begin
                            state          <= FLUSH;
                            data_out       <= shreg;
                            valid_bits_out <= bit_cnt - 4'd1;
                            parity_err_out <= 1'b0;
                            data_valid_out <= 1'b1;
                            byte_cnt       <= byte_cnt + 1'b1;
                        end else begin
                            state          <= REPORT;
                            frame_done_out <= 1'b1;
                            frame_err_out  <= bit_cnt == 4'd0 || byte_cnt == '0;
                        end
                    end else if (win_end) begin
                        prev_bit <= bit_val;
                        if (bit_cnt == 4'd8) begin
                            data_out       <= shreg;
                            valid_bits_out <= 4'd8;
                            parity_err_out <= (^{bit_val, shreg}) != PARITY_ODD;
                            data_valid_out <= 1'b1;
                            byte_cnt       <= byte_cnt + 1'b1;
                            bit_cnt        <= '0;
                            shreg          <= '0;
                        end else begin
                            shreg[bit_cnt[2:0]] <= bit_val;
                            bit_cnt             <= bit_cnt + 4'd1;
                        end
                    end
                end
                FLUSH: begin
                    state          <= REPORT;
                    frame_done_out <= 1'b1;
                    frame_err_out  <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    frame_err_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_miller_frame_decoder.sv
// tb_miller_frame_decoder: directed table-driven bench for the modified Miller frame decoder
module tb_miller_frame_decoder;
    localparam int T = 32;
    localparam int SY = 0, SZ = 1, SX = 2;

    logic       clk = 1'b0, rst = 1'b1, pause = 1'b0, rx_en = 1'b0;
    logic [7:0] data;
    logic [3:0] vbits;
    logic       perr, dvalid, fdone, ferr, busy;
    logic [5:0] bcount;

    miller_frame_decoder dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .pause_in       (pause),
        .rx_en_in       (rx_en),
        .data_out       (data),
        .valid_bits_out (vbits),
        .parity_err_out (perr),
        .data_valid_out (dvalid),
        .frame_done_out (fdone),
        .frame_err_out  (ferr),
        .byte_count_out (bcount),
        .busy_out       (busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, both = 0, cyc = 0, done_cyc = 0, t0 = 0;
    logic [12:0] dq[$];
    logic [6:0]  fq[$];
    int          sq[$];
    bit          pat[0:1023];

    typedef struct {
        logic [31:0] bits;
        int          n;
        int          jit;
        int          exp_n;
        logic [25:0] exp_s;
        logic        exp_err;
        logic [5:0]  exp_cnt;
    } vec_t;
    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dvalid) dq.push_back({data, vbits, perr});
        if (fdone) begin
            fq.push_back({ferr, bcount});
            done_cyc = cyc;
        end
        if (dvalid && fdone) both++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void encode(input logic [31:0] bits, input int n);
        logic prev = 1'b0;
        sq.delete();
        sq.push_back(SZ);
        for (int i = 0; i < n; i++) begin
            sq.push_back(bits[i] ? SX : (prev ? SY : SZ));
            prev = bits[i];
        end
        sq.push_back(prev ? SY : SZ);
        sq.push_back(SY);
    endfunction

    task automatic play(input int jit, input int cut);
        int len = sq.size() * T + 16;
        for (int c = 0; c < 1024; c++) pat[c] = 1'b0;
        for (int i = 0; i < sq.size(); i++)
            if (sq[i] != SY)
                for (int k = 0; k < 8; k++)
                    pat[i*T + (sq[i] == SX ? T/2 : 0) + (i > 0 ? jit : 0) + 8 + k] = 1'b1;
        t0 = cyc;
        for (int c = 0; c < len && c < cut; c++) begin
            @(posedge clk); #1 pause = pat[c];
        end
        @(posedge clk); #1 pause = 1'b0;
    endtask

    task automatic clear_q();
        dq.delete();
        fq.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h26,   7,  0, 1, {13'h0, 8'h26, 4'd7, 1'b0}, 1'b0, 6'd1};
        vecs[1] = '{32'h4193, 18, 0, 2, {8'h20, 4'd8, 1'b0, 8'h93, 4'd8, 1'b0}, 1'b0, 6'd2};
        vecs[2] = '{32'h093,  9,  0, 1, {13'h0, 8'h93, 4'd8, 1'b1}, 1'b0, 6'd1};
        vecs[3] = '{32'h26,   7,  3, 1, {13'h0, 8'h26, 4'd7, 1'b0}, 1'b0, 6'd1};
        vecs[4] = '{32'h26,   7, -3, 1, {13'h0, 8'h26, 4'd7, 1'b0}, 1'b0, 6'd1};
        vecs[5] = '{32'h0,    0,  0, 0, 26'h0, 1'b1, 6'd0};
        vecs[6] = '{32'h93,   8,  0, 1, {13'h0, 8'h93, 4'd8, 1'b1}, 1'b1, 6'd1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {data, vbits, perr, dvalid, fdone, ferr, bcount, busy}, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        clear_q();
        encode(32'h26, 7);
        play(0, 100000);
        repeat (60) @(posedge clk);
        chk("disarmed_strobes", dq.size(), 0);
        chk("disarmed_done", fq.size(), 0);
        #1 rx_en = 1'b1;
        repeat (4) @(posedge clk);

        for (int r = 0; r < 7; r++) begin
            clear_q();
            encode(vecs[r].bits, vecs[r].n);
            play(vecs[r].jit, 100000);
            repeat (60) @(posedge clk);
            chk($sformatf("v%0d_strobes", r), dq.size(), vecs[r].exp_n);
            for (int k = 0; k < dq.size() && k < vecs[r].exp_n; k++)
                chk($sformatf("v%0d_byte%0d", r, k), dq[k], vecs[r].exp_s[13*k +: 13]);
            chk($sformatf("v%0d_done", r), fq.size(), 1);
            if (fq.size() > 0) chk($sformatf("v%0d_err_cnt", r), fq[0], {vecs[r].exp_err, vecs[r].exp_cnt});
            chk($sformatf("v%0d_idle", r), busy, 0);
        end

        clear_q();
        sq.delete();
        sq.push_back(SZ); sq.push_back(SX); sq.push_back(SZ); sq.push_back(SY); sq.push_back(SY);
        play(0, 100000);
        repeat (60) @(posedge clk);
        chk("viol_strobes", dq.size(), 0);
        chk("viol_done", fq.size(), 1);
        if (fq.size() > 0) chk("viol_err", fq[0][6], 1);
        chk("viol_latency_ok", (done_cyc - (t0 + 73)) inside {[1:T+2]}, 1);

        clear_q();
        encode(32'h26, 7);
        play(0, 4*T);
        chk("busy_mid_frame", busy, 1);
        #1 rx_en = 1'b0;
        repeat (10) @(posedge clk);
        chk("drop_strobes", dq.size(), 0);
        chk("drop_done", fq.size(), 1);
        if (fq.size() > 0) chk("drop_err_cnt", fq[0], {1'b1, 6'd0});
        #1 rx_en = 1'b1;
        repeat (4) @(posedge clk);

        clear_q();
        encode(32'h26, 7);
        play(0, 5*T);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_outs", {data, vbits, perr, dvalid, fdone, ferr, bcount, busy}, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        encode(32'h26, 7);
        play(0, 100000);
        repeat (60) @(posedge clk);
        chk("midrst_strobes", dq.size(), 1);
        if (dq.size() > 0) chk("midrst_byte", dq[0], {8'h26, 4'd7, 1'b0});
        chk("midrst_done", fq.size(), 1);
        if (fq.size() > 0) chk("midrst_err_cnt", fq[0], {1'b0, 6'd1});

        chk("no_overlap", both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
